mux2_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 2-to-1 16-bit mux datapath.
- Two requesters (A, B) each present a valid/ready/last stream. The block grants one at a time, drives the mux select, and registers the selected word into a single output stage.
- Sits in front of the shared 16-bit consumer. Keeps bursts intact up to a fairness cap and switches between requesters without bubble cycles.

---
 rtl/mux2_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two valid/ready/last streams feeding a shared 2:1 mux,
// with a single registered output stage and a per-grant fairness cap.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W:0]   CAP = (CNT_W + 1)'(MAX_BURST);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               sel_q, sel_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_src_q, out_src_d;

  logic               load_ok;
  logic               acc;
  logic               gnt_valid;
  logic               gnt_last;
  logic               oth_valid;
  logic [WIDTH-1:0]   mux_data;
  logic [CNT_W:0]     cnt_inc;
  logic               release_now;

  assign load_ok   = !out_valid_q | out_ready;
  assign a_ready   = (state_q == GNT_A) & load_ok;
  assign b_ready   = (state_q == GNT_B) & load_ok;
  assign acc       = (a_valid & a_ready) | (b_valid & b_ready);

  // sel_q mirrors the grant, so it doubles as the "granted side" index.
  assign gnt_valid = sel_q ? b_valid : a_valid;
  assign gnt_last  = sel_q ? b_last  : a_last;
  assign oth_valid = sel_q ? a_valid : b_valid;
  assign mux_data  = sel_q ? b_data  : a_data;

  // >= rather than == so a saturated counter still splits once the other side shows up.
  assign cnt_inc     = {1'b0, beat_cnt_q} + (CNT_W + 1)'(1);
  assign release_now = acc & (gnt_last | ((cnt_inc >= CAP) & oth_valid));

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    case (state_q)
      IDLE: begin
        if (a_valid && b_valid) state_d = last_gnt_q ? GNT_A : GNT_B;
        else if (a_valid)       state_d = GNT_A;
        else if (b_valid)       state_d = GNT_B;
      end
      GNT_A, GNT_B: begin
        if (release_now) begin
          last_gnt_d = sel_q;
          beat_cnt_d = '0;
          if (oth_valid)                  state_d = sel_q ? GNT_A : GNT_B;
          else if (gnt_valid && gnt_last) state_d = state_q;
          else                            state_d = IDLE;
        end else if (acc) begin
          beat_cnt_d = (beat_cnt_q == SAT) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
        end else if (!gnt_valid && (beat_cnt_q == '0)) begin
          // Grant with no burst in progress and nothing offered: hand back to arbitration.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = gnt_last;
      out_src_d   = sel_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    sel_d = (state_d == GNT_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      beat_cnt_q  <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      beat_cnt_q  <= beat_cnt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: arbitration vector table plus scoreboarded burst sequences.
module tb_mux2_rr_arbiter;
  localparam int WIDTH     = 16;
  localparam int MAX_BURST = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, a_last, a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid, b_last, b_ready;
  logic [WIDTH-1:0] b_data;
  logic             sel, out_valid, out_last, out_src, out_ready, busy;
  logic [WIDTH-1:0] out_data;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready), .busy(busy)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    logic             src;
  } beat_t;

  typedef struct {
    logic av, bv, ordy;
    logic busy, sel, ar, br;
  } vec_t;

  beat_t a_src[$], b_src[$], exp_q[$];
  int    n_cmp = 0, n_err = 0;
  int    cyc = 0, n_fire = 0, first_cyc = -1, last_cyc = -1;
  logic  a_fire_s = 1'b0, b_fire_s = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sample mid-cycle, when all inputs and outputs are settled.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      a_fire_s = a_valid & a_ready & !rst;
      b_fire_s = b_valid & b_ready & !rst;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got data %0h src %0b, none expected", out_data, out_src);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_last", 32'(out_last), 32'(e.last));
          chk("out_src", 32'(out_src), 32'(e.src));
        end
        n_fire++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
  end

  // Source drivers: present the head of each queue, pop it once accepted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (a_fire_s && a_src.size() > 0) void'(a_src.pop_front());
      if (b_fire_s && b_src.size() > 0) void'(b_src.pop_front());
      a_valid = (a_src.size() > 0);
      a_data  = (a_src.size() > 0) ? a_src[0].data : '0;
      a_last  = (a_src.size() > 0) ? a_src[0].last : 1'b0;
      b_valid = (b_src.size() > 0);
      b_data  = (b_src.size() > 0) ? b_src[0].data : '0;
      b_last  = (b_src.size() > 0) ? b_src[0].last : 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic exp_push(input logic [WIDTH-1:0] d, input logic l, input logic s);
    beat_t e;
    e.data = d; e.last = l; e.src = s;
    exp_q.push_back(e);
  endtask

  task automatic push_a(input logic [WIDTH-1:0] d, input logic l, input logic ex);
    beat_t e;
    e.data = d; e.last = l; e.src = 1'b0;
    a_src.push_back(e);
    if (ex) exp_q.push_back(e);
  endtask

  task automatic push_b(input logic [WIDTH-1:0] d, input logic l, input logic ex);
    beat_t e;
    e.data = d; e.last = l; e.src = 1'b1;
    b_src.push_back(e);
    if (ex) exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_src.delete(); b_src.delete(); exp_q.delete();
    step();
    rst = 1'b0;
    n_fire = 0; first_cyc = -1; last_cyc = -1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [WIDTH-1:0] held;
    int k;
    rst = 1'b1; out_ready = 1'b1;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;

    vecs[0] = '{av:0, bv:0, ordy:1, busy:0, sel:0, ar:0, br:0};
    vecs[1] = '{av:1, bv:0, ordy:1, busy:1, sel:0, ar:1, br:0};
    vecs[2] = '{av:0, bv:1, ordy:1, busy:1, sel:1, ar:0, br:1};
    vecs[3] = '{av:1, bv:1, ordy:1, busy:1, sel:0, ar:1, br:0};
    vecs[4] = '{av:1, bv:0, ordy:0, busy:1, sel:0, ar:1, br:0};
    vecs[5] = '{av:0, bv:1, ordy:0, busy:1, sel:1, ar:0, br:1};

    // Reset state
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_src", 32'(out_src), 0);
    rst = 1'b0;

    // Arbitration out of IDLE straight after reset
    for (int i = 0; i < 6; i++) begin
      do_reset();
      out_ready = vecs[i].ordy;
      if (vecs[i].av) push_a(16'h0A5A, 1'b1, 1'b0);
      if (vecs[i].bv) push_b(16'h0B5B, 1'b1, 1'b0);
      step();
      step();
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ar));
      chk($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].br));
    end
    out_ready = 1'b1;

    // A only, 3 beats: grant one cycle after request, output one cycle after that
    do_reset();
    push_a(16'h1111, 1'b0, 1'b1);
    push_a(16'h2222, 1'b0, 1'b1);
    push_a(16'h3333, 1'b1, 1'b1);
    step();
    chk("a3_idle_busy", 32'(busy), 0);
    step();
    chk("a3_gnt_busy", 32'(busy), 1);
    chk("a3_gnt_a_ready", 32'(a_ready), 1);
    chk("a3_gnt_out_valid", 32'(out_valid), 0);
    step();
    chk("a3_first_out_valid", 32'(out_valid), 1);
    wait_drain("a3_drain", 10);
    chk("a3_span", 32'(last_cyc - first_cyc + 1), 3);
    k = 0;
    while (busy && k < 6) begin step(); k++; end
    chk("a3_back_to_idle", 32'(busy), 0);

    // Simultaneous first request
    do_reset();
    push_a(16'h1A00, 1'b0, 1'b1);
    push_a(16'h1A01, 1'b1, 1'b1);
    push_b(16'h1B00, 1'b0, 1'b1);
    push_b(16'h1B01, 1'b1, 1'b1);
    wait_drain("simul_drain", 12);
    chk("simul_span", 32'(last_cyc - first_cyc + 1), 4);

    // Fairness cap: 8 A beats, the waiting B beat, then the rest of A
    do_reset();
    for (int i = 0; i < 20; i++) push_a(16'hA000 + 16'(i), (i == 19), 1'b0);
    push_b(16'hB100, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) exp_push(16'hA000 + 16'(i), 1'b0, 1'b0);
    exp_push(16'hB100, 1'b1, 1'b1);
    for (int i = 8; i < 20; i++) exp_push(16'hA000 + 16'(i), (i == 19), 1'b0);
    wait_drain("fair_drain", 40);
    chk("fair_span", 32'(last_cyc - first_cyc + 1), 21);

    // Back-pressure during a B burst
    do_reset();
    for (int i = 0; i < 4; i++) push_b(16'hB001 + 16'(i), (i == 3), 1'b1);
    k = 0;
    while (!out_valid && k < 10) begin step(); k++; end
    chk("bp_out_valid", 32'(out_valid), 1);
    out_ready = 1'b0;
    #1;
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_b_ready", i), 32'(b_ready), 0);
      chk($sformatf("bp%0d_sel", i), 32'(sel), 1);
      chk($sformatf("bp%0d_out_data", i), 32'(out_data), 32'(held));
      chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 1);
      step();
    end
    out_ready = 1'b1;
    wait_drain("bp_drain", 12);

    // Reset in the middle of a 5-beat A burst
    do_reset();
    for (int i = 0; i < 5; i++) push_a(16'hC000 + 16'(i), (i == 4), 1'b1);
    k = 0;
    while (n_fire < 2 && k < 15) begin step(); k++; end
    chk("mrst_out_valid_before", 32'(out_valid), 1);
    rst = 1'b1;
    a_src.delete(); b_src.delete(); exp_q.delete();
    step();
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_sel", 32'(sel), 0);
    rst = 1'b0;
    push_a(16'hCA00, 1'b1, 1'b1);
    push_b(16'hCB00, 1'b1, 1'b1);
    step();
    step();
    chk("mrst_regrant_busy", 32'(busy), 1);
    chk("mrst_regrant_sel", 32'(sel), 0);
    wait_drain("mrst_drain", 10);

    // Alternation with single-beat bursts
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_a(16'hD0A0 + 16'(i), 1'b1, 1'b0);
      push_b(16'hD0B0 + 16'(i), 1'b1, 1'b0);
      exp_push(16'hD0A0 + 16'(i), 1'b1, 1'b0);
      exp_push(16'hD0B0 + 16'(i), 1'b1, 1'b1);
    end
    wait_drain("alt_drain", 20);
    chk("alt_span", 32'(last_cyc - first_cyc + 1), 8);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
